// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencing controller.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned WAIT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_WB_R   = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_WB_I   = 4'd5,
    ST_ADDR   = 4'd6,
    ST_MEM_RD = 4'd7,
    ST_WB_MEM = 4'd8,
    ST_MEM_WR = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  // ALU function codes
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;

  // ALU operand B select
  localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle driven by the sequencer
  typedef struct packed {
    logic                pc_wen;
    logic                ir_wen;
    logic                i_or_d;
    logic                rf_dst;
    logic                rf_wen;
    logic                data_rf;
    logic                alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_ren;
    logic                mem_wen;
    logic [SEL_W-1:0]    pc_src;
  } ctl_t;

  // States that wait on the memory handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Opcode/funct to ALU function decode with a supported-instruction flag.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  // Decode; any opcode/funct outside the supported set reports legal=0
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; legal = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_op = ALU_SUB;
        legal  = 1'b1;
      end
      OP_J: legal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle Moore sequencer for the MIPS-subset datapath, with
// cycle/retire counters and sticky illegal/timeout flags.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_wen,
  output logic                ir_wen,
  output logic                i_or_d,
  output logic                rf_dst,
  output logic                rf_wen,
  output logic                data_rf,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [SEL_W-1:0]    pc_src,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic                illegal,
  output logic                mem_timeout
);

  // Counter value on the last tolerated low-ready cycle; one more low cycle aborts
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_next;
  logic                waiting_c;
  logic                abort_c;
  logic                retire_c;
  logic                illegal_set_c;
  ctl_t                ctl_c;
  ctl_t                ctl_out_c;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_legal;

  mc_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // Memory wait tracking; ready in the limit cycle still counts as success
  assign waiting_c     = is_wait_state(state) & ~mem_ready;
  assign abort_c       = waiting_c & (wait_cnt == WAIT_LAST);
  assign wait_cnt_next = (waiting_c && !abort_c) ? wait_cnt + WAIT_W'(1) : '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // Next-state and Moore control decode
  always_comb begin
    state_next    = state;
    ctl_c         = '0;
    retire_c      = 1'b0;
    illegal_set_c = 1'b0;
    case (state)
      ST_FETCH: begin
        ctl_c.mem_ren   = 1'b1;
        ctl_c.alu_src_b = SRCB_FOUR;
        ctl_c.alu_op    = ALU_ADD;
        ctl_c.pc_src    = PCSRC_ALU;
        ctl_c.ir_wen    = mem_ready;
        ctl_c.pc_wen    = mem_ready;
        // An abort simply restarts the fetch in place
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ctl_c.alu_src_b = SRCB_IMM_SH2;
        ctl_c.alu_op    = ALU_ADD;
        state_next      = ST_FETCH;
        if (!dec_legal) begin
          illegal_set_c = 1'b1;
        end else begin
          case (opcode)
            OP_RTYPE:       state_next = ST_EXEC_R;
            OP_LW, OP_SW:   state_next = ST_ADDR;
            OP_ADDI:        state_next = ST_EXEC_I;
            OP_BEQ, OP_BNE: state_next = ST_BRANCH;
            OP_J:           state_next = ST_JUMP;
            default:        illegal_set_c = 1'b1;
          endcase
        end
      end
      ST_EXEC_R: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_RT;
        ctl_c.alu_op    = dec_alu_op;
        state_next      = ST_WB_R;
      end
      ST_WB_R: begin
        ctl_c.rf_dst = 1'b1;
        ctl_c.rf_wen = 1'b1;
        retire_c     = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_EXEC_I: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALU_ADD;
        state_next      = ST_WB_I;
      end
      ST_WB_I: begin
        ctl_c.rf_wen = 1'b1;
        retire_c     = 1'b1;
        state_next   = ST_FETCH;
      end
      ST_ADDR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_IMM;
        ctl_c.alu_op    = ALU_ADD;
        state_next      = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctl_c.mem_ren = 1'b1;
        ctl_c.i_or_d  = 1'b1;
        if (abort_c)        state_next = ST_FETCH;
        else if (mem_ready) state_next = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        ctl_c.data_rf = 1'b1;
        ctl_c.rf_wen  = 1'b1;
        retire_c      = 1'b1;
        state_next    = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctl_c.mem_wen = 1'b1;
        ctl_c.i_or_d  = 1'b1;
        if (abort_c) begin
          state_next = ST_FETCH;
        end else if (mem_ready) begin
          retire_c   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = SRCB_RT;
        ctl_c.alu_op    = ALU_SUB;
        ctl_c.pc_src    = PCSRC_ALUOUT;
        ctl_c.pc_wen    = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
        retire_c        = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_JUMP: begin
        ctl_c.pc_src = PCSRC_JUMP;
        ctl_c.pc_wen = 1'b1;
        retire_c     = 1'b1;
        state_next   = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Wait counter, event counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      cycle_cnt   <= '0;
      retire_cnt  <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_c)      retire_cnt  <= retire_cnt + CNT_W'(1);
      if (illegal_set_c) illegal     <= 1'b1;
      if (abort_c)       mem_timeout <= 1'b1;
    end
  end

  // Reset forces every enable and select low without waiting for a clock
  assign ctl_out_c = rst ? '0 : ctl_c;

  assign pc_wen    = ctl_out_c.pc_wen;
  assign ir_wen    = ctl_out_c.ir_wen;
  assign i_or_d    = ctl_out_c.i_or_d;
  assign rf_dst    = ctl_out_c.rf_dst;
  assign rf_wen    = ctl_out_c.rf_wen;
  assign data_rf   = ctl_out_c.data_rf;
  assign alu_src_a = ctl_out_c.alu_src_a;
  assign alu_src_b = ctl_out_c.alu_src_b;
  assign alu_op    = ctl_out_c.alu_op;
  assign mem_ren   = ctl_out_c.mem_ren;
  assign mem_wen   = ctl_out_c.mem_wen;
  assign pc_src    = ctl_out_c.pc_src;
  assign state_o   = state;

endmodule

// File: tb/tb_mc_control.sv
// Table-driven, scoreboarded bench for the multicycle sequencer.
module tb_mc_control;
  import mc_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_wen, ir_wen, i_or_d, rf_dst, rf_wen, data_rf, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        mem_ren, mem_wen;
  logic [1:0]  pc_src;
  logic [3:0]  state_o;
  logic [31:0] cycle_cnt, retire_cnt;
  logic        illegal, mem_timeout;

  mc_control #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_wen(pc_wen), .ir_wen(ir_wen), .i_or_d(i_or_d), .rf_dst(rf_dst),
    .rf_wen(rf_wen), .data_rf(data_rf), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .pc_src(pc_src), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_wen, ir_wen, i_or_d, rf_dst, rf_wen, data_rf, alu_src_a, alu_src_b, alu_op, mem_ren, mem_wen, pc_src}
  logic [16:0] act_ctl;
  assign act_ctl = {pc_wen, ir_wen, i_or_d, rf_dst, rf_wen, data_rf, alu_src_a,
                    alu_src_b, alu_op, mem_ren, mem_wen, pc_src};

  localparam logic [16:0] C_ZERO    = 17'd0;
  localparam logic [16:0] C_FETCH_R = {7'b1100000, 2'b01, 4'b0010, 2'b10, 2'b00};
  localparam logic [16:0] C_FETCH_W = {7'b0000000, 2'b01, 4'b0010, 2'b10, 2'b00};
  localparam logic [16:0] C_DECODE  = {7'b0000000, 2'b11, 4'b0010, 2'b00, 2'b00};
  localparam logic [16:0] C_EXR_ADD = {7'b0000001, 2'b00, 4'b0010, 2'b00, 2'b00};
  localparam logic [16:0] C_EXR_SUB = {7'b0000001, 2'b00, 4'b0110, 2'b00, 2'b00};
  localparam logic [16:0] C_EXR_SLT = {7'b0000001, 2'b00, 4'b0111, 2'b00, 2'b00};
  localparam logic [16:0] C_WBR     = {7'b0001100, 2'b00, 4'b0000, 2'b00, 2'b00};
  localparam logic [16:0] C_EXI     = {7'b0000001, 2'b10, 4'b0010, 2'b00, 2'b00};
  localparam logic [16:0] C_WBI     = {7'b0000100, 2'b00, 4'b0000, 2'b00, 2'b00};
  localparam logic [16:0] C_MRD     = {7'b0010000, 2'b00, 4'b0000, 2'b10, 2'b00};
  localparam logic [16:0] C_WBM     = {7'b0000110, 2'b00, 4'b0000, 2'b00, 2'b00};
  localparam logic [16:0] C_MWR     = {7'b0010000, 2'b00, 4'b0000, 2'b01, 2'b00};
  localparam logic [16:0] C_BR_T    = {7'b1000001, 2'b00, 4'b0110, 2'b00, 2'b01};
  localparam logic [16:0] C_BR_N    = {7'b0000001, 2'b00, 4'b0110, 2'b00, 2'b01};
  localparam logic [16:0] C_JMP     = {7'b1000000, 2'b00, 4'b0000, 2'b00, 2'b10};

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
    logic [31:0] cyc;
    logic        ill;
    logic        tmo;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic az, input logic mr, input logic [3:0] st,
                              input logic [16:0] ctl, input int ret,
                              input logic ill, input logic tmo);
    vec_t v;
    v.opcode = op; v.funct = fn; v.alu_zero = az; v.mem_ready = mr;
    v.st = st; v.ctl = ctl; v.ret = 32'(ret); v.cyc = 32'd0;
    v.ill = ill; v.tmo = tmo;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), score mid-cycle
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    opcode = v.opcode; funct = v.funct; alu_zero = v.alu_zero; mem_ready = v.mem_ready;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " ctl"},   64'(act_ctl),    64'(e.ctl));
    check({tag, " state"}, 64'(state_o),    64'(e.st));
    check({tag, " retire"},64'(retire_cnt), 64'(e.ret));
    check({tag, " cycle"}, 64'(cycle_cnt),  64'(e.cyc));
    check({tag, " illegal"}, 64'(illegal),  64'(e.ill));
    check({tag, " timeout"}, 64'(mem_timeout), 64'(e.tmo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0; mem_ready = 1'b1;

    // add, then lw with three wait cycles (ready arrives on the limit cycle)
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, ST_FETCH,  C_FETCH_R, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, ST_DECODE, C_DECODE,  0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, ST_EXEC_R, C_EXR_ADD, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, ST_WB_R,   C_WBR,     0, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, ST_DECODE, C_DECODE,  1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, ST_ADDR,   C_EXI,     1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 0, ST_MEM_RD, C_MRD,     1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 0, ST_MEM_RD, C_MRD,     1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 0, ST_MEM_RD, C_MRD,     1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, ST_MEM_RD, C_MRD,     1, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 1, ST_WB_MEM, C_WBM,     1, 0, 0));
    // sw with a one-cycle fetch stall
    tbl.push_back(mk(6'h2B, 6'h00, 0, 0, ST_FETCH,  C_FETCH_W, 2, 0, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 2, 0, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_DECODE, C_DECODE,  2, 0, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_ADDR,   C_EXI,     2, 0, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_MEM_WR, C_MWR,     2, 0, 0));
    // beq taken, bne with zero (not taken), bne without zero (taken)
    tbl.push_back(mk(6'h04, 6'h00, 1, 1, ST_FETCH,  C_FETCH_R, 3, 0, 0));
    tbl.push_back(mk(6'h04, 6'h00, 1, 1, ST_DECODE, C_DECODE,  3, 0, 0));
    tbl.push_back(mk(6'h04, 6'h00, 1, 1, ST_BRANCH, C_BR_T,    3, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 1, 1, ST_FETCH,  C_FETCH_R, 4, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 1, 1, ST_DECODE, C_DECODE,  4, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 1, 1, ST_BRANCH, C_BR_N,    4, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 5, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 0, 1, ST_DECODE, C_DECODE,  5, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 0, 1, ST_BRANCH, C_BR_T,    5, 0, 0));
    // addi, j
    tbl.push_back(mk(6'h08, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 6, 0, 0));
    tbl.push_back(mk(6'h08, 6'h00, 0, 1, ST_DECODE, C_DECODE,  6, 0, 0));
    tbl.push_back(mk(6'h08, 6'h00, 0, 1, ST_EXEC_I, C_EXI,     6, 0, 0));
    tbl.push_back(mk(6'h08, 6'h00, 0, 1, ST_WB_I,   C_WBI,     6, 0, 0));
    tbl.push_back(mk(6'h02, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 7, 0, 0));
    tbl.push_back(mk(6'h02, 6'h00, 0, 1, ST_DECODE, C_DECODE,  7, 0, 0));
    tbl.push_back(mk(6'h02, 6'h00, 0, 1, ST_JUMP,   C_JMP,     7, 0, 0));
    // illegal opcode 0x3F, then sub and slt with the flag held
    tbl.push_back(mk(6'h3F, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 8, 0, 0));
    tbl.push_back(mk(6'h3F, 6'h00, 0, 1, ST_DECODE, C_DECODE,  8, 0, 0));
    tbl.push_back(mk(6'h00, 6'h22, 0, 1, ST_FETCH,  C_FETCH_R, 8, 1, 0));
    tbl.push_back(mk(6'h00, 6'h22, 0, 1, ST_DECODE, C_DECODE,  8, 1, 0));
    tbl.push_back(mk(6'h00, 6'h22, 0, 1, ST_EXEC_R, C_EXR_SUB, 8, 1, 0));
    tbl.push_back(mk(6'h00, 6'h22, 0, 1, ST_WB_R,   C_WBR,     8, 1, 0));
    tbl.push_back(mk(6'h00, 6'h2A, 0, 1, ST_FETCH,  C_FETCH_R, 9, 1, 0));
    tbl.push_back(mk(6'h00, 6'h2A, 0, 1, ST_DECODE, C_DECODE,  9, 1, 0));
    tbl.push_back(mk(6'h00, 6'h2A, 0, 1, ST_EXEC_R, C_EXR_SLT, 9, 1, 0));
    tbl.push_back(mk(6'h00, 6'h2A, 0, 1, ST_WB_R,   C_WBR,     9, 1, 0));
    // sw with ready stuck low: abort after four wait cycles, no retire
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_FETCH,  C_FETCH_R, 10, 1, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_DECODE, C_DECODE,  10, 1, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, ST_ADDR,   C_EXI,     10, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(6'h2B, 6'h00, 0, 0, ST_MEM_WR, C_MWR,   10, 1, 0));
    tbl.push_back(mk(6'h00, 6'h20, 0, 1, ST_FETCH,  C_FETCH_R, 10, 1, 1));

    // Reset state: everything low even though FETCH would drive mem_ren
    repeat (2) @(posedge clk);
    #1;
    check("reset ctl",    64'(act_ctl),    64'(C_ZERO));
    check("reset state",  64'(state_o),    64'(ST_FETCH));
    check("reset cycle",  64'(cycle_cnt),  64'd0);
    check("reset retire", 64'(retire_cnt), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.cyc = 32'(i);
      apply(v, $sformatf("v%0d", i));
    end

    // add: decode, then asynchronous reset in the middle of EXEC_R
    v = mk(6'h00, 6'h20, 0, 1, ST_DECODE, C_DECODE, 10, 1, 1);
    v.cyc = 32'(tbl.size());
    apply(v, "pre_rst decode");
    #1;
    check("pre_rst exec ctl",   64'(act_ctl), 64'(C_EXR_ADD));
    check("pre_rst exec state", 64'(state_o), 64'(ST_EXEC_R));
    rst = 1'b1;
    #1;
    check("async rst ctl",     64'(act_ctl),     64'(C_ZERO));
    check("async rst state",   64'(state_o),     64'(ST_FETCH));
    check("async rst cycle",   64'(cycle_cnt),   64'd0);
    check("async rst retire",  64'(retire_cnt),  64'd0);
    check("async rst illegal", 64'(illegal),     64'd0);
    check("async rst timeout", 64'(mem_timeout), 64'd0);
    @(posedge clk);
    #1;
    check("held rst state", 64'(state_o), 64'(ST_FETCH));
    rst = 1'b0;

    // Fresh fetch right after release, then an R-type with an unsupported funct
    begin
      vec_t seq[$];
      seq.push_back(mk(6'h00, 6'h20, 0, 1, ST_FETCH,  C_FETCH_R, 0, 0, 0));
      seq.push_back(mk(6'h00, 6'h20, 0, 1, ST_DECODE, C_DECODE,  0, 0, 0));
      seq.push_back(mk(6'h00, 6'h20, 0, 1, ST_EXEC_R, C_EXR_ADD, 0, 0, 0));
      seq.push_back(mk(6'h00, 6'h20, 0, 1, ST_WB_R,   C_WBR,     0, 0, 0));
      seq.push_back(mk(6'h00, 6'h3F, 0, 1, ST_FETCH,  C_FETCH_R, 1, 0, 0));
      seq.push_back(mk(6'h00, 6'h3F, 0, 1, ST_DECODE, C_DECODE,  1, 0, 0));
      seq.push_back(mk(6'h00, 6'h20, 0, 1, ST_FETCH,  C_FETCH_R, 1, 1, 0));
      for (int i = 0; i < seq.size(); i++) begin
        v = seq[i];
        v.cyc = 32'(i);
        apply(v, $sformatf("post_rst%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle sequencing controller for the MIPS-subset datapath: PC, IR, register file, ALU, data memory.
- Replaces the single-cycle decoder. Each instruction runs as a Moore FSM sequence, and memory accesses wait on a ready handshake.
- Also provides cycle and retired-instruction counters, plus sticky illegal-instruction and memory-timeout flags, for the test outputs.

Parameters:
- CNT_W, 32: width of cycle_cnt and retire_cnt.
- WAIT_LIMIT, 255: consecutive mem_ready-low cycles in a wait state before timeout abort (range 1..255).

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- opcode  in  6: IR[31:26]; stable from DECODE until the next FETCH.
- funct  in  6: IR[5:0].
- alu_zero  in  1: ALU zero flag.
- mem_ready  in  1: memory completes the current access this cycle.
- pc_wen  out  1: PC write.
- ir_wen  out  1: IR write.
- i_or_d  out  1: memory address source; 0 = PC, 1 = ALUOut.
- rf_dst  out  1: register write address; 1 = rd, 0 = rt.
- rf_wen  out  1: register file write.
- data_rf  out  1: register write data; 1 = MDR, 0 = ALUOut.
- alu_src_a  out  1: 0 = PC, 1 = rs.
- alu_src_b  out  2: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- alu_op  out  4: ALU function code.
- mem_ren  out  1: memory read.
- mem_wen  out  1: memory write.
- pc_src  out  2: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- state_o  out  4: current state, for debug.
- cycle_cnt  out  CNT_W: cycles since reset.
- retire_cnt  out  CNT_W: instructions completed.
- illegal  out  1: sticky; an unsupported instruction was decoded.
- mem_timeout  out  1: sticky; a memory wait hit WAIT_LIMIT.

Behaviour:

Reset:
- While rst is high: state = FETCH, counters = 0, sticky flags = 0, wait counter = 0.
- All enables (pc_wen, ir_wen, rf_wen, mem_ren, mem_wen) and all select outputs are forced to 0.
- Reset asserted mid-instruction abandons it; nothing retires.

Supported instructions:
- R-type (opcode 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.

ALU codes:
- AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.

Output timing:
- Outputs are Moore: decoded combinationally from the state register and opcode/funct.
- The only Mealy terms are pc_wen/ir_wen gated by mem_ready, and pc_wen gated by alu_zero.

States and outputs:
- FETCH: mem_ren=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00; ir_wen=pc_wen=mem_ready. Next state is DECODE on mem_ready, otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state:
  - R-type with legal funct -> EXEC_R
  - lw/sw -> ADDR
  - addi -> EXEC_I
  - beq/bne -> BRANCH
  - j -> JUMP
  - anything else -> FETCH, and set illegal.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct -> WB_R.
- WB_R: rf_dst=1, data_rf=0, rf_wen=1; retire -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD -> WB_I.
- WB_I: rf_dst=0, data_rf=0, rf_wen=1; retire -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_ren=1, i_or_d=1; on mem_ready -> WB_MEM.
- WB_MEM: rf_dst=0, data_rf=1, rf_wen=1; retire -> FETCH.
- MEM_WR: mem_wen=1, i_or_d=1; on mem_ready retire -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_wen = alu_zero for beq, ~alu_zero for bne.
  - Retire -> FETCH (taken or not).
- JUMP: pc_src=10, pc_wen=1; retire -> FETCH.

Memory timeout (wait states FETCH, MEM_RD, MEM_WR):
- An 8-bit wait counter increments each cycle mem_ready is low and clears on state change.
- When it reaches WAIT_LIMIT with mem_ready still low: set mem_timeout, go to FETCH, no retire.
  - In FETCH, this means restarting the fetch.
  - No pc_wen is issued on abort.
- mem_ready high in the same cycle as the limit counts as success.

Counters:
- cycle_cnt increments every cycle rst is low.
- retire_cnt increments on each retire cycle listed above.
- Both wrap from all-ones to 0 with no flag.

Sticky flags:
- illegal and mem_timeout clear only on reset.

Decomposition:
- Package mc_pkg holds:
  - state encodings (4-bit localparams)
  - opcode and funct constants
  - ALU code constants
  - alu_src_b and pc_src select codes.
- One natural sub-module, mc_alu_dec: combinational funct/opcode -> alu_op plus a legal flag. It is reusable by the single-cycle Control.

Test Plan:
- add $3,$1,$2 (opcode 0, funct 0x20), mem_ready=1 always:
  - states FETCH, DECODE, EXEC_R, WB_R over 4 cycles
  - rf_wen=1 with rf_dst=1 in WB_R only
  - alu_op=0010 in EXEC_R
  - retire_cnt 0 -> 1.
- lw with mem_ready low 3 cycles in MEM_RD:
  - 5 base states + 3 wait cycles = 8 cycles
  - mem_ren and i_or_d held high through the wait
  - rf_wen only in WB_MEM, with data_rf=1.
- beq with alu_zero=1, then bne with alu_zero=1:
  - beq: pc_wen=1 in BRANCH
  - bne: pc_wen=0 in BRANCH
  - both retire (retire_cnt +2)
  - pc_src=01 in both.
- Opcode 0x3F:
  - DECODE -> FETCH
  - illegal=1 and stays 1 across a following legal add
  - retire_cnt not incremented for 0x3F.
- WAIT_LIMIT=4, mem_ready stuck low in MEM_WR:
  - after 4 wait cycles, mem_timeout=1 and state=FETCH
  - mem_wen deasserted, no retire, no pc_wen.
- Assert rst asynchronously mid-EXEC_R:
  - outputs go 0 immediately, before the next clock edge
  - state_o=FETCH, counters=0
  - after release, the first fetch starts on the next edge.
